// File: rtl/ines_loader.sv
// Purpose : parses an iNES byte stream and writes the PRG and CHR images into cart memories.
// Latency : each accepted PRG/CHR byte is written one cycle later (registered write port).
// Backpressure : in_ready is high while loading and low once the image is done or the header is rejected.
//
// Ports:
//   clk_cpu, rst_n                : single rising-edge clock, asynchronous active-low reset
//   in_data, in_valid, in_ready   : iNES file byte stream; a byte moves when in_valid and in_ready are both high
//   prg_addr, prg_data, prg_we    : PRG memory write port (one write per accepted PRG byte)
//   chr_addr, chr_data, chr_we    : CHR memory write port (one write per accepted CHR byte)
//   mirrorv, mapper               : header fields handed to the cart
//   done, error                   : image fully loaded / header rejected; both hold until reset
//
// Build option: define INES_TRAINER_SKIP_EN to skip a 512-byte trainer (header byte 6 bit 2).
// Without it, a header that announces a trainer is rejected.

module ines_loader #(
  parameter int PRG_AW = 15,
  parameter int CHR_AW = 13
) (
  input  logic              clk_cpu,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PRG_AW-1:0] prg_addr,
  output logic [7:0]        prg_data,
  output logic              prg_we,
  output logic [CHR_AW-1:0] chr_addr,
  output logic [7:0]        chr_data,
  output logic              chr_we,
  output logic              mirrorv,
  output logic [7:0]        mapper,
  output logic              done,
  output logic              error
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] ST_HEADER  = 3'd0;
`ifdef INES_TRAINER_SKIP_EN
  localparam logic [2:0] ST_TRAINER = 3'd1;
`endif
  localparam logic [2:0] ST_PRG     = 3'd2;
  localparam logic [2:0] ST_CHR     = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_ERROR   = 3'd5;

  // Largest image each memory can hold, in bytes.
  localparam logic [31:0] PRG_LIMIT = 32'd1 << PRG_AW;
  localparam logic [31:0] CHR_LIMIT = 32'd1 << CHR_AW;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [3:0]        hdr_cnt;
  logic [7:0]        prg_banks;
  // Counters and terminal counts carry one extra bit so a full-size image
  // (exactly 2^AW bytes) is representable without wrapping to zero.
  logic [PRG_AW:0]   prg_cnt;
  logic [PRG_AW:0]   prg_total;
  logic [CHR_AW:0]   chr_cnt;
  logic [CHR_AW:0]   chr_total;
`ifdef INES_TRAINER_SKIP_EN
  logic              has_trainer;
  logic [8:0]        trn_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic              accept;
  logic [31:0]       prg_bytes;
  logic [31:0]       chr_bytes;
  logic              size_bad;
  logic [PRG_AW:0]   prg_cnt_inc;
  logic [CHR_AW:0]   chr_cnt_inc;

  assign accept = in_valid & in_ready;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    magic_byte = 8'h4E;
      2'd1:    magic_byte = 8'h45;
      2'd2:    magic_byte = 8'h53;
      default: magic_byte = 8'h1A;
    endcase
  endfunction

  // Size legality is judged while byte 5 (chr_banks) is on the bus, using the
  // prg_banks value latched from byte 4. Arithmetic is done at 32 bits so the
  // largest bank counts cannot overflow before the compare.
  always_comb begin
    prg_bytes = {24'd0, prg_banks} << 14;
    chr_bytes = {24'd0, in_data} << 13;
    size_bad  = (prg_banks == 8'd0) || (prg_bytes > PRG_LIMIT) || (chr_bytes > CHR_LIMIT);
  end

  assign prg_cnt_inc = prg_cnt + 1'b1;
  assign chr_cnt_inc = chr_cnt + 1'b1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      ST_HEADER: begin
        if (accept) begin
          if (hdr_cnt < 4'd4) begin
            if (in_data != magic_byte(hdr_cnt[1:0])) state_nx = ST_ERROR;
          end else if (hdr_cnt == 4'd5) begin
            if (size_bad) state_nx = ST_ERROR;
          end else if (hdr_cnt == 4'd6) begin
`ifndef INES_TRAINER_SKIP_EN
            // No trainer support in this build: such an image cannot be loaded.
            if (in_data[2]) state_nx = ST_ERROR;
`endif
          end else if (hdr_cnt == 4'd15) begin
`ifdef INES_TRAINER_SKIP_EN
            state_nx = has_trainer ? ST_TRAINER : ST_PRG;
`else
            state_nx = ST_PRG;
`endif
          end
        end
      end
`ifdef INES_TRAINER_SKIP_EN
      ST_TRAINER: begin
        if (accept && (trn_cnt == 9'd511)) state_nx = ST_PRG;
      end
`endif
      ST_PRG: begin
        if (accept && (prg_cnt_inc == prg_total)) begin
          // No CHR banks means the cart uses CHR-RAM; nothing more to load.
          state_nx = (chr_total != '0) ? ST_CHR : ST_DONE;
        end
      end
      ST_CHR: begin
        if (accept && (chr_cnt_inc == chr_total)) state_nx = ST_DONE;
      end
      default: state_nx = state; // DONE and ERROR hold until reset
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_HEADER;
      in_ready    <= 1'b0;
      hdr_cnt     <= '0;
      prg_banks   <= '0;
      prg_cnt     <= '0;
      prg_total   <= '0;
      chr_cnt     <= '0;
      chr_total   <= '0;
      prg_addr    <= '0;
      prg_data    <= '0;
      prg_we      <= 1'b0;
      chr_addr    <= '0;
      chr_data    <= '0;
      chr_we      <= 1'b0;
      mirrorv     <= 1'b0;
      mapper      <= '0;
`ifdef INES_TRAINER_SKIP_EN
      has_trainer <= 1'b0;
      trn_cnt     <= '0;
`endif
    end else begin
      state    <= state_nx;
      // Registered from the next state so ready drops on the same edge that
      // enters DONE/ERROR, and first rises one edge after reset releases.
      in_ready <= (state_nx != ST_DONE) && (state_nx != ST_ERROR);
      prg_we   <= 1'b0;
      chr_we   <= 1'b0;

      if (accept) begin
        case (state)
          ST_HEADER: begin
            hdr_cnt <= hdr_cnt + 1'b1;
            case (hdr_cnt)
              4'd4: prg_banks <= in_data;
              4'd5: begin
                prg_total <= prg_bytes[PRG_AW:0];
                chr_total <= chr_bytes[CHR_AW:0];
              end
              4'd6: begin
                mirrorv     <= in_data[0];
                mapper[3:0] <= in_data[7:4];
`ifdef INES_TRAINER_SKIP_EN
                has_trainer <= in_data[2];
`endif
              end
              4'd7: mapper[7:4] <= in_data[7:4];
              default: ; // magic already checked; bytes 8-15 are unused
            endcase
          end
`ifdef INES_TRAINER_SKIP_EN
          ST_TRAINER: trn_cnt <= trn_cnt + 1'b1;
`endif
          ST_PRG: begin
            prg_we   <= 1'b1;
            prg_data <= in_data;
            prg_addr <= prg_cnt[PRG_AW-1:0];
            prg_cnt  <= prg_cnt_inc;
          end
          ST_CHR: begin
            chr_we   <= 1'b1;
            chr_data <= in_data;
            chr_addr <= chr_cnt[CHR_AW-1:0];
            chr_cnt  <= chr_cnt_inc;
          end
          default: ;
        endcase
      end
    end
  end

  assign done  = (state == ST_DONE);
  assign error = (state == ST_ERROR);

endmodule

// File: doc/ines_loader.md
INES_LOADER -- requirements
Module: ines_loader

Interface
REQ-001 The block SHALL have parameter PRG_AW, default 15, the PRG image address width (32 KiB max).
REQ-002 The block SHALL have parameter CHR_AW, default 13, the CHR image address width (8 KiB max).
REQ-003 The block SHALL have port clk_cpu, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port in_data, input, 8, the iNES file byte stream.
REQ-006 The block SHALL have port in_valid, input, 1, which qualifies in_data.
REQ-007 The block SHALL have port in_ready, output, 1; a byte is accepted on a cycle with in_valid and in_ready both high.
REQ-008 The block SHALL have ports prg_addr (output, PRG_AW), prg_data (output, 8) and prg_we (output, 1), the PRG memory write port.
REQ-009 The block SHALL have ports chr_addr (output, CHR_AW), chr_data (output, 8) and chr_we (output, 1), the CHR memory write port.
REQ-010 The block SHALL have ports mirrorv (output, 1) and mapper (output, 8), the header fields handed to the cart.
REQ-011 The block SHALL have ports done (output, 1), meaning the image is loaded, and error (output, 1), meaning the header was rejected.

Function
REQ-012 The state machine SHALL have the states HEADER, TRAINER, PRG, CHR, DONE and ERROR, and SHALL enter HEADER out of reset.
REQ-013 In HEADER, the block SHALL count 16 accepted bytes (0-15).
REQ-014 Bytes 0-3 SHALL equal 4E 45 53 1A; any mismatch SHALL move the block to ERROR on the cycle after that byte.
REQ-015 The block SHALL latch byte 4 as prg_banks (16 KiB units) and byte 5 as chr_banks (8 KiB units).
REQ-016 The block SHALL latch mirrorv from byte6[0], and mapper as {byte7[7:4], byte6[7:4]}; bytes 8-15 SHALL be ignored.
REQ-017 After byte 5, the block SHALL go to ERROR if prg_banks==0, if prg_banks*16384 > 2^PRG_AW, or if chr_banks*8192 > 2^CHR_AW.
REQ-018 After byte 15, the block SHALL go to TRAINER (see REQ-030) or to PRG.
REQ-019 In PRG, each accepted byte SHALL produce, on the next cycle, prg_we=1 for one cycle with prg_data equal to that byte.
REQ-020 prg_addr SHALL start at 0 and increment by 1 after each write, giving a write latency of one cycle.
REQ-021 After prg_banks*16384 bytes, the block SHALL go to CHR if chr_banks!=0, otherwise to DONE (CHR-RAM cart).
REQ-022 CHR SHALL behave as PRG using the chr_* port, and SHALL end after chr_banks*8192 bytes, then go to DONE.
REQ-023 in_ready SHALL be 1 in HEADER, TRAINER, PRG and CHR, and 0 in DONE and ERROR; bytes offered in DONE or ERROR SHALL be ignored.
REQ-024 in_valid low SHALL stall the block with no writes, and no counter or state change.
REQ-025 Byte counters SHALL be PRG_AW+1 or CHR_AW+1 bits wide so that a full-size image count does not wrap before the terminal compare.
REQ-026 done SHALL be 1 only in DONE, and error only in ERROR; both states SHALL be terminal until reset.

Reset
REQ-027 When rst_n=0, the block SHALL asynchronously force state=HEADER, all counters to 0, and outputs in_ready=0, prg_we=chr_we=0, prg_addr=chr_addr=0, prg_data=chr_data=0, mirrorv=0, mapper=0, done=0 and error=0.
REQ-028 in_ready SHALL rise on the first clk_cpu edge after rst_n deasserts.
REQ-029 Reset asserted mid-load SHALL abort the load with no further writes; the next load SHALL restart at header byte 0.

Configuration
REQ-030 When macro INES_TRAINER_SKIP_EN is defined and byte6[2]=1, the block SHALL pass through TRAINER, discarding exactly 512 accepted bytes with no writes, before PRG.
REQ-031 When INES_TRAINER_SKIP_EN is undefined, the block SHALL go to ERROR if byte6[2]=1, and TRAINER SHALL not exist.

Verification
REQ-032 Header 4E 45 53 1A 02 01 01 00 + 8x00, then 32768 PRG bytes and 8192 CHR bytes (data = addr[7:0]) -> prg_we pulses 32768 times to addresses 0..7FFF, chr_we pulses 8192 times; mirrorv=1, mapper=00, done=1, in_ready=0.
REQ-033 Header byte 2 = 54 -> error=1 on the cycle after byte 2; no prg_we; later bytes ignored.
REQ-034 byte4=01, byte5=00, then 16384 bytes -> writes to 0000..3FFF only, no chr_we, done=1.
REQ-035 byte4=03 -> error=1 after byte 5 (48 KiB > 32 KiB).
REQ-036 in_valid toggled with a 1-in-3 duty during PRG, then rst_n pulsed low after 100 PRG bytes -> no writes on idle cycles; outputs reset immediately; a reload completes with prg_addr starting at 0.
REQ-037 With INES_TRAINER_SKIP_EN, byte6=04 plus 512 bytes of FF before PRG -> no FF written, first prg_we at address 0; without the macro -> error=1.
